// File: rtl/riscv_branch_pkg.sv
// Shared definitions for the RV32I branch resolution unit: funct3 codes,
// FSM state encoding and small decode helpers.
package riscv_branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    BR_IDLE = 2'd0,
    BR_CMP  = 2'd1,
    BR_DONE = 2'd2
  } br_state_e;

  function automatic logic is_signed(input logic [2:0] f3);
    return f3[2:1] == 2'b10;
  endfunction

  function automatic logic is_illegal(input logic [2:0] f3);
    return f3[2:1] == 2'b01;
  endfunction

  // Final branch decision from the resolved equal / less-than flags.
  function automatic logic branch_taken(input logic [2:0] f3, input logic eq, input logic lt);
    logic t;
    t = 1'b0;
    case (f3)
      F3_BEQ:           t = eq;
      F3_BNE:           t = !eq;
      F3_BLT, F3_BLTU:  t = lt;
      F3_BGE, F3_BGEU:  t = !lt;
      default:          t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/branch_slice_cmp.sv
// One-slice magnitude comparator; sign_flip turns an unsigned compare of the
// top slice into a two's-complement compare by inverting its MSB.
module branch_slice_cmp #(
  parameter int unsigned SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             sign_flip,
  output logic             eq,
  output logic             lt
);

  logic [SLICE-1:0] flip_mask;
  logic [SLICE-1:0] a_s;
  logic [SLICE-1:0] b_s;

  assign flip_mask = SLICE'(sign_flip) << (SLICE - 1);
  assign a_s       = a ^ flip_mask;
  assign b_s       = b ^ flip_mask;
  assign eq        = (a_s == b_s);
  assign lt        = (a_s < b_s);

endmodule

// File: rtl/branch_resolve_unit.sv
// Multi-cycle B-type branch resolver: serial MSB-first slice compare with
// optional early exit, branch target adder and misalignment flag.
module branch_resolve_unit
  import riscv_branch_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SLICE      = 8,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            taken,
  output logic [XLEN-1:0] target,
  output logic            illegal,
  output logic            misaligned
);

  localparam int unsigned NSLICE = XLEN / SLICE;
  localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  br_state_e        state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [XLEN-1:0]  a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]  target_d;
  logic [2:0]       f3_q, f3_d;
  logic             found_q, found_d;
  logic             lt_q, lt_d;
  logic             taken_d, illegal_d, misaligned_d, out_valid_d;
  logic             s_eq, s_lt, sign_flip;
  logic             finish, fin_eq, fin_lt;

  assign in_ready  = resetn && (state_q == BR_IDLE) && !flush;
  // Operands shift left each CMP cycle, so the active slice is always the top one.
  assign sign_flip = is_signed(f3_q) && (idx_q == IDXW'(NSLICE - 1));

  branch_slice_cmp #(.SLICE(SLICE)) u_slice_cmp (
    .a         (a_q[XLEN-1 -: SLICE]),
    .b         (b_q[XLEN-1 -: SLICE]),
    .sign_flip (sign_flip),
    .eq        (s_eq),
    .lt        (s_lt)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    a_d           = a_q;
    b_d           = b_q;
    f3_d          = f3_q;
    found_d       = found_q;
    lt_d          = lt_q;
    target_d      = target;
    taken_d       = taken;
    illegal_d     = illegal;
    misaligned_d  = misaligned;
    out_valid_d   = out_valid;
    finish        = 1'b0;
    fin_eq        = 1'b0;
    fin_lt        = 1'b0;

    if (flush) begin
      state_d      = BR_IDLE;
      out_valid_d  = 1'b0;
      taken_d      = 1'b0;
      illegal_d    = 1'b0;
      misaligned_d = 1'b0;
    end else begin
      case (state_q)
        BR_IDLE: begin
          if (in_valid && in_ready) begin
            a_d          = op_a;
            b_d          = op_b;
            f3_d         = funct3;
            target_d     = pc + imm;
            idx_d        = IDXW'(NSLICE - 1);
            found_d      = 1'b0;
            lt_d         = 1'b0;
            taken_d      = 1'b0;
            misaligned_d = 1'b0;
            illegal_d    = is_illegal(funct3);
            if (is_illegal(funct3)) begin
              state_d     = BR_DONE;
              out_valid_d = 1'b1;
            end else begin
              state_d     = BR_CMP;
            end
          end
        end
        BR_CMP: begin
          a_d   = a_q << SLICE;
          b_d   = b_q << SLICE;
          idx_d = idx_q - IDXW'(1);
          if (EARLY_EXIT && !s_eq) begin
            finish = 1'b1;
            fin_eq = 1'b0;
            fin_lt = s_lt;
          end else begin
            // Full-scan mode keeps only the first (most significant) difference.
            if (!s_eq && !found_q) begin
              found_d = 1'b1;
              lt_d    = s_lt;
            end
            if (idx_q == '0) begin
              finish = 1'b1;
              fin_eq = !found_d;
              fin_lt = lt_d;
            end
          end
          if (finish) begin
            state_d      = BR_DONE;
            out_valid_d  = 1'b1;
            taken_d      = branch_taken(f3_q, fin_eq, fin_lt);
            misaligned_d = taken_d && (target[1:0] != 2'b00);
          end
        end
        BR_DONE: begin
          if (out_ready) begin
            state_d     = BR_IDLE;
            out_valid_d = 1'b0;
          end
        end
        default: state_d = BR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= BR_IDLE;
      idx_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      f3_q       <= '0;
      found_q    <= 1'b0;
      lt_q       <= 1'b0;
      target     <= '0;
      taken      <= 1'b0;
      illegal    <= 1'b0;
      misaligned <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      a_q        <= a_d;
      b_q        <= b_d;
      f3_q       <= f3_d;
      found_q    <= found_d;
      lt_q       <= lt_d;
      target     <= target_d;
      taken      <= taken_d;
      illegal    <= illegal_d;
      misaligned <= misaligned_d;
      out_valid  <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench: an early-exit and a full-scan instance share stimulus;
// results, latency, stall, flush and reset behaviour are checked.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        in_valid;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b, pc, imm;
  logic        out_ready;

  logic        in_ready0, out_valid0, taken0, illegal0, misaligned0;
  logic [31:0] target0;
  logic        in_ready1, out_valid1, taken1, illegal1, misaligned1;
  logic [31:0] target1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(32), .SLICE(8), .EARLY_EXIT(1'b1)) dut_ee (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .funct3(funct3), .op_a(op_a), .op_b(op_b), .pc(pc), .imm(imm),
    .out_valid(out_valid0), .out_ready(out_ready), .taken(taken0), .target(target0),
    .illegal(illegal0), .misaligned(misaligned0)
  );

  branch_resolve_unit #(.XLEN(32), .SLICE(8), .EARLY_EXIT(1'b0)) dut_fs (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .funct3(funct3), .op_a(op_a), .op_b(op_b), .pc(pc), .imm(imm),
    .out_valid(out_valid1), .out_ready(out_ready), .taken(taken1), .target(target1),
    .illegal(illegal1), .misaligned(misaligned1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Present one request on the negedge; the following posedge is the accept edge.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic [31:0] i);
    @(negedge clk);
    funct3 = f3; op_a = a; op_b = b; pc = p; imm = i;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Latency = rising edges after the accept edge until out_valid is seen.
  task automatic run(input string tag, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] p, input logic [31:0] i,
                     input logic exp_taken, input logic [31:0] exp_tgt, input logic exp_ill,
                     input logic exp_mis, input int exp_lat0, input int exp_lat1);
    int cyc;
    int lat0, lat1;
    logic tk0, tk1, il0, ms0;
    logic [31:0] tg0;
    lat0 = 99; lat1 = 99;
    tk0 = 1'b0; tk1 = 1'b0; il0 = 1'b0; ms0 = 1'b0; tg0 = '0;
    issue(f3, a, b, p, i);
    cyc = 0;
    while ((lat0 == 99 || lat1 == 99) && cyc < 20) begin
      if (lat0 == 99 && out_valid0) begin
        lat0 = cyc; tk0 = taken0; tg0 = target0; il0 = illegal0; ms0 = misaligned0;
      end
      if (lat1 == 99 && out_valid1) begin
        lat1 = cyc; tk1 = taken1;
      end
      if (lat0 == 99 || lat1 == 99) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk({tag, ".taken"},   32'(tk0),  32'(exp_taken));
    chk({tag, ".target"},  tg0,       exp_tgt);
    chk({tag, ".illegal"}, 32'(il0),  32'(exp_ill));
    chk({tag, ".misal"},   32'(ms0),  32'(exp_mis));
    chk({tag, ".lat_ee"},  32'(lat0), 32'(exp_lat0));
    chk({tag, ".taken_fs"},32'(tk1),  32'(exp_taken));
    chk({tag, ".lat_fs"},  32'(lat1), 32'(exp_lat1));
    @(negedge clk);
  endtask

  initial begin
    int seen;
    int cnt;
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    funct3 = '0; op_a = '0; op_b = '0; pc = '0; imm = '0;

    #3;
    chk("rst.in_ready",  32'(in_ready0),  32'd0);
    chk("rst.out_valid", 32'(out_valid0), 32'd0);
    chk("rst.taken",     32'(taken0),     32'd0);
    chk("rst.target",    target0,         32'd0);
    chk("rst.illegal",   32'(illegal0),   32'd0);
    chk("rst.misal",     32'(misaligned0), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("rst.in_ready_rel", 32'(in_ready0), 32'd1);

    //  tag       f3      a             b             pc            imm          tk tgt           il ms ee fs
    run("beq_eq",  3'b000, 32'd12,       32'd12,       32'h0000_1000, 32'h0000_0020, 1, 32'h0000_1020, 0, 0, 4, 4);
    run("bltu_hi", 3'b110, 32'hffff_1234, 32'h0fff_1234, 32'h0000_2000, 32'hffff_fff0, 0, 32'h0000_1ff0, 0, 0, 1, 4);
    run("blt_neg", 3'b100, 32'hffff_ffff, 32'd1,       32'h0000_3000, 32'h0000_0100, 1, 32'h0000_3100, 0, 0, 1, 4);
    run("bge_low", 3'b101, 32'd42,       32'd41,       32'h0000_0040, 32'h0000_0008, 1, 32'h0000_0048, 0, 0, 4, 4);
    run("bgeu_hi", 3'b111, 32'h0fff_1234, 32'hffff_1234, 32'h0000_0400, 32'h0000_0010, 0, 32'h0000_0410, 0, 0, 1, 4);
    run("bge_min", 3'b101, 32'h8000_0000, 32'h7fff_ffff, 32'hffff_fffc, 32'h0000_0008, 0, 32'h0000_0004, 0, 0, 1, 4);
    run("ill_010", 3'b010, 32'hffff_ffff, 32'hffff_ffff, 32'h0000_0500, 32'h0000_0004, 0, 32'h0000_0504, 1, 0, 0, 0);
    run("ill_011", 3'b011, 32'hffff_ffff, 32'hffff_ffff, 32'h0000_0600, 32'h0000_0004, 0, 32'h0000_0604, 1, 0, 0, 0);
    run("bne_mis", 3'b001, 32'd5,        32'd3,        32'h0000_0100, 32'h0000_0006, 1, 32'h0000_0106, 0, 1, 4, 4);
    run("bne_nt",  3'b001, 32'd7,        32'd7,        32'h0000_0100, 32'h0000_0002, 0, 32'h0000_0102, 0, 0, 4, 4);

    // Consumer stall holds the result.
    out_ready = 1'b0;
    issue(3'b110, 32'h0fff_1234, 32'hffff_1234, 32'h0000_0200, 32'h0000_0040);
    cnt = 0;
    while (!out_valid0 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("stall.lat", 32'(cnt), 32'd1);
    for (int k = 0; k < 3; k++) begin
      chk("stall.out_valid", 32'(out_valid0), 32'd1);
      chk("stall.taken",     32'(taken0),     32'd1);
      chk("stall.target",    target0,         32'h0000_0240);
      chk("stall.in_ready",  32'(in_ready0),  32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall.rel_valid", 32'(out_valid0), 32'd0);
    chk("stall.rel_ready", 32'(in_ready0),  32'd1);
    repeat (6) @(negedge clk);

    // Flush in the second CMP cycle drops the request.
    issue(3'b000, 32'd12, 32'd12, 32'h0000_0700, 32'h0000_0004);
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush.in_ready_low", 32'(in_ready0), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush.in_ready", 32'(in_ready0),  32'd1);
    chk("flush.valid",    32'(out_valid0), 32'd0);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid0 || out_valid1) seen = 1;
    end
    chk("flush.no_emit", 32'(seen), 32'd0);

    // Reset asserted mid-compare clears immediately and emits nothing.
    issue(3'b000, 32'd12, 32'd12, 32'h0000_0800, 32'h0000_0010);
    resetn = 1'b0;
    #1;
    chk("rstmid.in_ready", 32'(in_ready0),  32'd0);
    chk("rstmid.target",   target0,         32'd0);
    chk("rstmid.valid",    32'(out_valid0), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid0 || out_valid1) seen = 1;
    end
    chk("rstmid.no_emit", 32'(seen), 32'd0);

    run("post_rst", 3'b100, 32'd1, 32'hffff_ffff, 32'h0000_0900, 32'h0000_0002, 0, 32'h0000_0902, 0, 0, 1, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
